// File: rtl/alu_multdiv.sv
// alu_multdiv: multicycle signed multiply (shift-add) / divide (restoring) unit.
// Operates on operand magnitudes; the sign is applied when the result is registered.
module alu_multdiv #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e             state_q;
   logic               op_div_q;
   logic               sign_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [W2-1:0]      a_q;        // multiplicand (shifts left) or divisor (static, low half)
   logic [WIDTH-1:0]   b_q;        // multiplier (shifts right) or dividend/quotient
   logic [W2-1:0]      acc_q;      // product or partial remainder
   logic [WIDTH-1:0]   result_q;
   logic               exc_q;
   logic               rdy_q;
   logic               busy_q;

   logic               start_c;
   logic [WIDTH-1:0]   abs_a_c;
   logic [WIDTH-1:0]   abs_b_c;
   logic [WIDTH:0]     div_shift_c;
   logic [WIDTH:0]     div_diff_c;
   logic               div_ge_c;
   logic [W2-1:0]      prod_c;
   logic               mul_ovf_c;
   logic [WIDTH-1:0]   quot_c;
   logic               div_zero_c;
   logic               div_ovf_c;

   // Start decode, operand magnitudes, one restoring-divide step and final sign/overflow logic
   always_comb begin
      start_c     = ctrl_MULT ^ ctrl_DIV;
      abs_a_c     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
      abs_b_c     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
      div_shift_c = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
      div_ge_c    = div_shift_c >= {1'b0, a_q[WIDTH-1:0]};
      div_diff_c  = div_shift_c - {1'b0, a_q[WIDTH-1:0]};
      prod_c      = sign_q ? (~acc_q + W2'(1)) : acc_q;
      mul_ovf_c   = !((&prod_c[W2-1:WIDTH-1]) || !(|prod_c[W2-1:WIDTH-1]));
      quot_c      = sign_q ? (~b_q + WIDTH'(1)) : b_q;
      div_zero_c  = (a_q[WIDTH-1:0] == '0);
      div_ovf_c   = !sign_q && b_q[WIDTH-1];
   end

   // Control FSM, datapath iteration and registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_div_q <= 1'b0;
         sign_q   <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (start_c) begin
            // A start in any state aborts whatever is running
            state_q  <= ctrl_DIV ? S_DIV : S_MUL;
            op_div_q <= ctrl_DIV;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            if (ctrl_DIV) begin
               a_q <= W2'(abs_b_c);
               b_q <= abs_a_c;
            end else begin
               a_q <= W2'(abs_a_c);
               b_q <= abs_b_c;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  busy_q <= 1'b0;
               end
               S_MUL: begin
                  if (b_q[0]) acc_q <= acc_q + a_q;
                  a_q <= a_q << 1;
                  b_q <= b_q >> 1;
                  if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
                  else                            cnt_q   <= cnt_q + CNT_W'(1);
               end
               S_DIV: begin
                  if (div_ge_c) begin
                     acc_q <= W2'(div_diff_c);
                     b_q   <= {b_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_q <= W2'(div_shift_c);
                     b_q   <= {b_q[WIDTH-2:0], 1'b0};
                  end
                  if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
                  else                            cnt_q   <= cnt_q + CNT_W'(1);
               end
               S_DONE: begin
                  rdy_q   <= 1'b1;
                  state_q <= S_IDLE;
                  if (!op_div_q) begin
                     result_q <= prod_c[WIDTH-1:0];
                     exc_q    <= mul_ovf_c;
                  end else if (div_zero_c) begin
                     result_q <= '0;
                     exc_q    <= 1'b1;
                  end else begin
                     result_q <= quot_c;
                     exc_q    <= div_ovf_c;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// tb_alu_multdiv: directed vector table plus hand-written restart/abort/reset sequences.
module tb_alu_multdiv;

   logic        clock;
   logic        reset_n;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        mul;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t vecs[14];

   alu_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive a start for one edge; operands are scrambled afterwards (don't-care)
   task automatic start_op(input logic mul, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT     = mul;
      ctrl_DIV      = !mul;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Count edges after the start until RDY is seen; -1 on timeout
   task automatic wait_rdy(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            lat = i;
            break;
         end
      end
   endtask

   // Watch n edges, counting RDY pulses and the edge of the first one
   task automatic watch(input int n, output int pulses, output int first, output int busy_seen);
      pulses    = 0;
      first     = -1;
      busy_seen = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clock);
         #1;
         if (busy) busy_seen++;
         if (data_resultRDY) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
   endtask

   initial begin
      int lat;
      int pulses;
      int first;
      int bcnt;

      vecs[0]  = '{1'b1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{1'b1, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1};
      vecs[2]  = '{1'b1, 32'h80000000,   32'd1,        32'h80000000, 1'b0};
      vecs[3]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{1'b0, 32'd100,        32'd7,        32'd14,       1'b0};
      vecs[5]  = '{1'b0, 32'd5,          32'd0,        32'd0,        1'b1};
      vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
      vecs[7]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
      vecs[8]  = '{1'b0, 32'd0,          32'd5,        32'd0,        1'b0};
      vecs[9]  = '{1'b1, 32'hFFFFFFFC,   32'hFFFFFFFB, 32'd20,       1'b0};
      vecs[10] = '{1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       1'b0};
      vecs[11] = '{1'b0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
      vecs[12] = '{1'b1, 32'h7FFFFFFF,   32'd2,        32'hFFFFFFFE, 1'b1};
      vecs[13] = '{1'b1, 32'h40000000,   32'hFFFFFFFE, 32'h80000000, 1'b0};

      reset_n       = 1'b0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset result", data_result, 32'd0);
      check("reset exc", 32'(data_exception), 32'd0);
      check("reset rdy", 32'(data_resultRDY), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Table-driven vectors
      for (int v = 0; v < 14; v++) begin
         start_op(vecs[v].mul, vecs[v].a, vecs[v].b);
         check($sformatf("v%0d busy after start", v), 32'(busy), 32'd1);
         wait_rdy(lat);
         check($sformatf("v%0d latency", v), 32'(lat), 32'd33);
         check($sformatf("v%0d result", v), data_result, vecs[v].res);
         check($sformatf("v%0d exc", v), 32'(data_exception), 32'(vecs[v].exc));
         check($sformatf("v%0d busy on rdy", v), 32'(busy), 32'd1);
         @(posedge clock);
         #1;
         check($sformatf("v%0d busy after", v), 32'(busy), 32'd0);
         check($sformatf("v%0d rdy pulse", v), 32'(data_resultRDY), 32'd0);
         check($sformatf("v%0d result hold", v), data_result, vecs[v].res);
      end

      // Restart: DIV issued 10 edges into a MUL
      start_op(1'b1, 32'd3, 32'd4);
      watch(9, pulses, first, bcnt);
      check("restart early rdy", 32'(pulses), 32'd0);
      start_op(1'b0, 32'd100, 32'd7);
      watch(40, pulses, first, bcnt);
      check("restart rdy count", 32'(pulses), 32'd1);
      check("restart latency", 32'(first), 32'd33);
      check("restart result", data_result, 32'd14);

      // Both control lines high: ignored
      @(negedge clock);
      ctrl_MULT     = 1'b1;
      ctrl_DIV      = 1'b1;
      data_operandA = 32'd9;
      data_operandB = 32'd3;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      check("both busy", 32'(busy), 32'd0);
      watch(40, pulses, first, bcnt);
      check("both rdy count", 32'(pulses), 32'd0);
      check("both busy count", 32'(bcnt), 32'd0);
      check("both result kept", data_result, 32'd14);

      // Reset in the middle of a multiply
      start_op(1'b1, 32'd3, 32'd4);
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("midreset result", data_result, 32'd0);
      check("midreset exc", 32'(data_exception), 32'd0);
      check("midreset rdy", 32'(data_resultRDY), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      watch(40, pulses, first, bcnt);
      check("midreset rdy count", 32'(pulses), 32'd0);

      // Back-to-back: second start on the RDY cycle
      start_op(1'b1, 32'd3, 32'd4);
      wait_rdy(lat);
      check("b2b first latency", 32'(lat), 32'd33);
      check("b2b first result", data_result, 32'd12);
      start_op(1'b0, 32'd100, 32'd7);
      check("b2b busy kept", 32'(busy), 32'd1);
      wait_rdy(lat);
      check("b2b second latency", 32'(lat), 32'd33);
      check("b2b second result", data_result, 32'd14);
      check("b2b second exc", 32'(data_exception), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
